// File: rtl/rob_core_pkg.sv
// rob_core shared definitions.
// Tag widths and the reserved tag values.
package rob_core_pkg;

  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int ROB_NULL_TAG    = 0;
  localparam int ROB_FIRST_TAG   = 1;

  typedef struct packed {
    logic        ready;
    logic [31:0] value;
  } rob_look_t;

endpackage

// File: rtl/rob_ptr_next.sv
// ROB pointer increment.
// Wraps from the top tag back to the first tag, never producing tag 0.
import rob_core_pkg::*;

module rob_ptr_next #(
  parameter int W = ROB_ENTRY_WIDTH
) (
  input  logic [W-1:0] ptr,
  output logic [W-1:0] next
);

  // next tag, skipping the reserved null tag
  always_comb begin
    next = ptr + W'(1);
    if (ptr == {W{1'b1}})
      next = W'(ROB_FIRST_TAG);
  end

endmodule

// File: rtl/rob_core.sv
// Reorder buffer storage and control.
// Allocates tags, takes CDB writebacks, serves lookups, commits in order.
import rob_core_pkg::*;

module rob_core #(
  parameter int ROB_ENTRY_WIDTH = rob_core_pkg::ROB_ENTRY_WIDTH,
  parameter int REG_ADDR_WIDTH  = rob_core_pkg::REG_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_dest_reg,
  output logic                       alloc_ready,
  output logic [ROB_ENTRY_WIDTH-1:0] alloc_index,
  input  logic                       cdb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] cdb_index,
  input  logic [31:0]                cdb_value,
  input  logic [ROB_ENTRY_WIDTH-1:0] rd_a_index,
  output logic                       rd_a_ready,
  output logic [31:0]                rd_a_value,
  input  logic [ROB_ENTRY_WIDTH-1:0] rd_b_index,
  output logic                       rd_b_ready,
  output logic [31:0]                rd_b_value,
  output logic                       commit_valid,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_index,
  output logic [REG_ADDR_WIDTH-1:0]  commit_dest_reg,
  output logic [31:0]                commit_value,
  output logic [ROB_ENTRY_WIDTH-1:0] count
);

  localparam int W = ROB_ENTRY_WIDTH;
  localparam int N = 2 ** W;

  logic [N-1:0]              busy_q;
  logic [N-1:0]              rdy_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q [N];
  logic [31:0]               val_q  [N];
  logic [W-1:0]              head_q;
  logic [W-1:0]              tail_q;
  logic [W-1:0]              cnt_q;
  logic [W-1:0]              head_nx;
  logic [W-1:0]              tail_nx;
  logic                      alloc_fire;
  logic                      cdb_fire;
  rob_look_t                 look_a;
  rob_look_t                 look_b;

  rob_ptr_next #(.W(W)) u_head_nx (
    .ptr (head_q),
    .next(head_nx)
  );

  rob_ptr_next #(.W(W)) u_tail_nx (
    .ptr (tail_q),
    .next(tail_nx)
  );

  function automatic rob_look_t lookup(input logic [W-1:0] idx);
    rob_look_t r;
    r = '0;
    unique case (1'b1)
      (idx == W'(ROB_NULL_TAG)):
        r = '{ready: 1'b1, value: 32'd0};
      (idx != W'(ROB_NULL_TAG) && busy_q[idx] && rdy_q[idx]):
        r = '{ready: 1'b1, value: val_q[idx]};
      (idx != W'(ROB_NULL_TAG) && busy_q[idx] && !rdy_q[idx]
        && cdb_valid && cdb_index == idx):
        r = '{ready: 1'b1, value: cdb_value};
      default:
        r = '0;
    endcase
    return r;
  endfunction

  // handshake, commit and lookup outputs from registered state
  always_comb begin
    alloc_ready     = (cnt_q != {W{1'b1}});
    alloc_index     = tail_q;
    alloc_fire      = alloc_valid && alloc_ready;
    cdb_fire        = cdb_valid && cdb_index != W'(ROB_NULL_TAG)
                      && busy_q[cdb_index] && !rdy_q[cdb_index];
    commit_valid    = (cnt_q != '0) && rdy_q[head_q];
    commit_index    = '0;
    commit_dest_reg = '0;
    commit_value    = '0;
    if (commit_valid) begin
      commit_index    = head_q;
      commit_dest_reg = dest_q[head_q];
      commit_value    = val_q[head_q];
    end
    look_a     = lookup(rd_a_index);
    look_b     = lookup(rd_b_index);
    rd_a_ready = look_a.ready;
    rd_a_value = look_a.value;
    rd_b_ready = look_b.ready;
    rd_b_value = look_b.value;
    count      = cnt_q;
  end

  // entry state, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      rdy_q  <= '0;
      for (int i = 0; i < N; i++) begin
        dest_q[i] <= '0;
        val_q[i]  <= '0;
      end
      head_q <= W'(ROB_FIRST_TAG);
      tail_q <= W'(ROB_FIRST_TAG);
      cnt_q  <= '0;
    end else if (flush) begin
      busy_q <= '0;
      rdy_q  <= '0;
      head_q <= W'(ROB_FIRST_TAG);
      tail_q <= W'(ROB_FIRST_TAG);
      cnt_q  <= '0;
    end else begin
      if (alloc_fire) begin
        busy_q[tail_q] <= 1'b1;
        rdy_q[tail_q]  <= 1'b0;
        val_q[tail_q]  <= '0;
        dest_q[tail_q] <= alloc_dest_reg;
        tail_q         <= tail_nx;
      end
      if (cdb_fire) begin
        rdy_q[cdb_index] <= 1'b1;
        val_q[cdb_index] <= cdb_value;
      end
      if (commit_valid) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_nx;
      end
      cnt_q <= cnt_q + W'(alloc_fire) - W'(commit_valid);
    end
  end

endmodule

// File: tb/tb_rob_core.sv
// rob_core directed testbench.
// Hand-computed vectors for reset, fill, writeback, wrap and flush.
module tb_rob_core;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_dest_reg;
  logic        alloc_ready;
  logic [2:0]  alloc_index;
  logic        cdb_valid;
  logic [2:0]  cdb_index;
  logic [31:0] cdb_value;
  logic [2:0]  rd_a_index;
  logic        rd_a_ready;
  logic [31:0] rd_a_value;
  logic [2:0]  rd_b_index;
  logic        rd_b_ready;
  logic [31:0] rd_b_value;
  logic        commit_valid;
  logic [2:0]  commit_index;
  logic [4:0]  commit_dest_reg;
  logic [31:0] commit_value;
  logic [2:0]  count;

  int checks;
  int failures;

  rob_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_dest_reg (alloc_dest_reg),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .cdb_valid      (cdb_valid),
    .cdb_index      (cdb_index),
    .cdb_value      (cdb_value),
    .rd_a_index     (rd_a_index),
    .rd_a_ready     (rd_a_ready),
    .rd_a_value     (rd_a_value),
    .rd_b_index     (rd_b_index),
    .rd_b_ready     (rd_b_ready),
    .rd_b_value     (rd_b_value),
    .commit_valid   (commit_valid),
    .commit_index   (commit_index),
    .commit_dest_reg(commit_dest_reg),
    .commit_value   (commit_value),
    .count          (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_dest_reg = '0;
    cdb_valid      = 1'b0;
    cdb_index      = '0;
    cdb_value      = '0;
    rd_a_index     = '0;
    rd_b_index     = '0;
    #12 rst_n = 1'b1;

    // dirty the state, then reset mid-cycle
    tick();
    alloc_valid = 1'b1;
    alloc_dest_reg = 5'd3;
    tick();
    tick();
    idle();
    #2;
    check("pre_rst_count", count, 2);
    rst_n = 1'b0;
    rd_b_index = 3'd1;
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_index", alloc_index, 1);
    check("rst_count", count, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_value", commit_value, 0);
    check("rst_rd_a0_ready", rd_a_ready, 1);
    check("rst_rd_a0_value", rd_a_value, 0);
    check("rst_rd_b1_ready", rd_b_ready, 0);
    #6 rst_n = 1'b1;

    // fill: 8 allocs, the 8th rejected
    tick();
    for (int i = 1; i <= 8; i++) begin
      alloc_valid = 1'b1;
      alloc_dest_reg = 5'(i);
      #1;
      if (i <= 7) begin
        check("fill_index", alloc_index, i);
        check("fill_ready", alloc_ready, 1);
      end else begin
        check("full_ready", alloc_ready, 0);
      end
      tick();
    end
    idle();
    #1;
    check("full_count", count, 7);
    check("full_index", alloc_index, 1);

    // out-of-order writeback with same-cycle bypass
    cdb_valid = 1'b1;
    cdb_index = 3'd2;
    cdb_value = 32'hDEADBEEF;
    rd_a_index = 3'd2;
    #1;
    check("byp_ready", rd_a_ready, 1);
    check("byp_value", rd_a_value, 32'hDEADBEEF);
    check("wb2_no_commit", commit_valid, 0);
    tick();
    cdb_index = 3'd1;
    cdb_value = 32'h11;
    #1;
    check("wb1_no_commit", commit_valid, 0);
    tick();
    // second write to already-ready tag 1 must be ignored
    cdb_value = 32'h22;
    rd_a_index = 3'd1;
    #1;
    check("c1_valid", commit_valid, 1);
    check("c1_index", commit_index, 1);
    check("c1_reg", commit_dest_reg, 1);
    check("c1_value", commit_value, 32'h11);
    check("rdy_tag1_value", rd_a_value, 32'h11);
    tick();
    idle();
    #1;
    check("c2_valid", commit_valid, 1);
    check("c2_index", commit_index, 2);
    check("c2_reg", commit_dest_reg, 2);
    check("c2_value", commit_value, 32'hDEADBEEF);
    tick();
    check("after_c2_count", count, 5);
    check("head3_wait", commit_valid, 0);

    // retire 3..7 while allocating tags 1..3
    cdb_valid = 1'b1;
    cdb_index = 3'd3;
    cdb_value = 32'h33;
    tick();
    for (int k = 0; k < 5; k++) begin
      alloc_valid = (k < 3);
      alloc_dest_reg = 5'(9 + k);
      cdb_valid = (k < 4);
      cdb_index = 3'(4 + k);
      cdb_value = 32'h34 + 32'(k);
      #1;
      check("wr_cvalid", commit_valid, 1);
      check("wr_cindex", commit_index, 3 + k);
      check("wr_creg", commit_dest_reg, 3 + k);
      check("wr_cvalue", commit_value, 32'h33 + 32'(k));
      if (k < 3)
        check("wr_alloc_index", alloc_index, 1 + k);
      tick();
      check("wr_count", count, (k < 3) ? 5 : 5 - (k - 2));
    end
    idle();
    #1;
    check("wrap_count", count, 3);
    check("wrap_tail", alloc_index, 4);
    check("wrap_no_commit", commit_valid, 0);

    // fourth busy entry, then flush with a CDB write
    alloc_valid = 1'b1;
    alloc_dest_reg = 5'd12;
    tick();
    idle();
    #1;
    check("pre_flush_count", count, 4);
    flush = 1'b1;
    cdb_valid = 1'b1;
    cdb_index = 3'd3;
    cdb_value = 32'h99;
    tick();
    idle();
    rd_b_index = 3'd3;
    #1;
    check("flush_count", count, 0);
    check("flush_index", alloc_index, 1);
    check("flush_rdb3_ready", rd_b_ready, 0);
    check("flush_rdb3_value", rd_b_value, 0);

    // write to a non-busy tag
    cdb_valid = 1'b1;
    cdb_index = 3'd5;
    cdb_value = 32'h55;
    tick();
    idle();
    rd_b_index = 3'd5;
    #1;
    check("nb5_ready", rd_b_ready, 0);
    check("nb5_value", rd_b_value, 0);
    check("nb5_count", count, 0);
    check("nb5_commit", commit_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
